// File: rtl/spi_master_rx.sv
// Receive-only SPI master (mode 0, MSB first): on request, clocks one DATA_W-bit frame in from the sensor.
// Frame result appears with a one-cycle valid pulse; spi_not_busy is high only while idle.
module spi_master_rx #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 5,
  parameter int CBITS   = $clog2(2*DATA_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ena,
  input  logic              miso,
  output logic              spi_not_busy,
  output logic [DATA_W-1:0] spi_rx_data,
  output logic              spi_rx_valid,
  output logic              cs_n,
  output logic              sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CBITS-1:0]  edge_q, edge_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              tick;

  assign tick = (div_q == DIV_W'(CLK_DIV-1));

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    edge_d     = edge_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        sclk_d = 1'b0;
        if (spi_ena) state_d = SETUP;
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          edge_d  = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          // sclk currently low means this tick is a rising edge: sample now
          if (!sclk_q) shift_d = {shift_q[DATA_W-2:0], miso};
          if (edge_q == CBITS'(2*DATA_W-1)) begin
            state_d = HOLD;
            edge_d  = '0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = DONE;
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (tick) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        edge_d  = '0;
        sclk_d  = 1'b0;
      end
    endcase
    // Chip select follows the state being entered so it stays a clean register output
    cs_n_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign spi_not_busy = (state_q == IDLE);
  assign spi_rx_data  = rx_data_q;
  assign spi_rx_valid = rx_valid_q;
  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;

endmodule

// File: tb/tb_spi_master_rx.sv
// Bench for spi_master_rx: MAX31855-style sensor models driving two instances (CLK_DIV=5 and CLK_DIV=1).
// Frames are scoreboarded: expected words queued at request time, compared once the DUT reports them.
module tb_spi_master_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena_a = 1'b0, ena_b = 1'b0;
  logic        miso_a = 1'b0, miso_b = 1'b0;
  logic        nb_a, nb_b, vld_a, vld_b, cs_a, cs_b, sclk_a, sclk_b;
  logic [31:0] data_a, data_b;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  spi_master_rx #(.DATA_W(32), .CLK_DIV(5)) dut_a (
    .clk(clk), .rst(rst), .spi_ena(ena_a), .miso(miso_a),
    .spi_not_busy(nb_a), .spi_rx_data(data_a), .spi_rx_valid(vld_a),
    .cs_n(cs_a), .sclk(sclk_a)
  );

  spi_master_rx #(.DATA_W(32), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .spi_ena(ena_b), .miso(miso_b),
    .spi_not_busy(nb_b), .spi_rx_data(data_b), .spi_rx_valid(vld_b),
    .cs_n(cs_b), .sclk(sclk_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sensor models: first bit on cs_n fall, next bit on every sclk fall
  logic [31:0] sens_q_a[$], sens_q_b[$];
  logic [31:0] sw_a, sw_b;
  bit          loaded_a = 0, loaded_b = 0;

  always @(cs_a or negedge sclk_a) begin
    if (cs_a === 1'b1) loaded_a = 0;
    else if (cs_a === 1'b0 && !loaded_a) begin
      sw_a = 32'h0;
      if (sens_q_a.size() > 0) sw_a = sens_q_a.pop_front();
      loaded_a = 1;
      miso_a = sw_a[31];
      sw_a = sw_a << 1;
    end else if (cs_a === 1'b0 && sclk_a === 1'b0) begin
      miso_a = sw_a[31];
      sw_a = sw_a << 1;
    end
  end

  always @(cs_b or negedge sclk_b) begin
    if (cs_b === 1'b1) loaded_b = 0;
    else if (cs_b === 1'b0 && !loaded_b) begin
      sw_b = 32'h0;
      if (sens_q_b.size() > 0) sw_b = sens_q_b.pop_front();
      loaded_b = 1;
      miso_b = sw_b[31];
      sw_b = sw_b << 1;
    end else if (cs_b === 1'b0 && sclk_b === 1'b0) begin
      miso_b = sw_b[31];
      sw_b = sw_b << 1;
    end
  end

  // Monitors: free-running counters and observed-word queues
  int busy_a = 0, valid_a = 0, rise_a = 0, hi_run = 0;
  int busy_b = 0, valid_b = 0, rise_b = 0;
  int gaps[$];
  logic [31:0] rx_q_a[$], rx_q_b[$], exp_q_a[$], exp_q_b[$];

  always @(negedge clk) begin
    if (nb_a === 1'b0) busy_a++;
    if (vld_a === 1'b1) begin
      valid_a++;
      rx_q_a.push_back(data_a);
    end
    if (cs_a === 1'b1) hi_run++;
    else if (hi_run != 0) begin
      gaps.push_back(hi_run);
      hi_run = 0;
    end
    if (nb_b === 1'b0) busy_b++;
    if (vld_b === 1'b1) begin
      valid_b++;
      rx_q_b.push_back(data_b);
    end
  end

  always @(posedge sclk_a) rise_a++;
  always @(posedge sclk_b) rise_b++;

  logic [31:0] last_a = 32'h0;

  task automatic score_a(input string tag);
    logic [31:0] got, exp;
    if (exp_q_a.size() == 0 || rx_q_a.size() == 0) begin
      chk({tag, "_present"}, 32'(rx_q_a.size()), 32'(exp_q_a.size()));
    end else begin
      got = rx_q_a.pop_front();
      exp = exp_q_a.pop_front();
      chk(tag, got, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic [31:0] word, input bit rnd);
    int  b0, r0, v0, t;
    bit  mid_done;
    b0 = busy_a; r0 = rise_a; v0 = valid_a; t = 0; mid_done = 0;
    sens_q_a.push_back(word);
    exp_q_a.push_back(word);
    ena_a = 1'b1;
    @(negedge clk);
    ena_a = rnd ? 1'($urandom_range(1)) : 1'b0;
    while (vld_a !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
      if (rnd) ena_a = 1'($urandom_range(1));
      if (!mid_done && rise_a - r0 >= 20) begin
        mid_done = 1;
        chk({tag, "_hold_prev"}, data_a, last_a);
      end
    end
    ena_a = 1'b0;
    while (nb_a !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (t >= 2000) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_busy"}, 32'(busy_a - b0), 32'd335);
    chk({tag, "_rises"}, 32'(rise_a - r0), 32'd32);
    chk({tag, "_vcnt"}, 32'(valid_a - v0), 32'd1);
    score_a(tag);
    last_a = word;
  endtask

  initial begin
    int t, r0, v0, b0, g0, nv;

    // Reset state
    @(negedge clk);
    chk("rst_cs_n", 32'(cs_a), 32'd1);
    chk("rst_sclk", 32'(sclk_a), 32'd0);
    chk("rst_nb", 32'(nb_a), 32'd1);
    chk("rst_data", data_a, 32'h0);
    chk("rst_vld", 32'(vld_a), 32'd0);
    chk("rst_cs_n_b", 32'(cs_b), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame
    run_a("t1", 32'hA5C3_0F81, 0);

    // Back-to-back frames with ena held
    b0 = busy_a; r0 = rise_a; g0 = gaps.size(); nv = 0; t = 0;
    sens_q_a.push_back(32'h0000_0001); exp_q_a.push_back(32'h0000_0001);
    sens_q_a.push_back(32'h8000_0000); exp_q_a.push_back(32'h8000_0000);
    sens_q_a.push_back(32'hFFFF_FFFF); exp_q_a.push_back(32'hFFFF_FFFF);
    ena_a = 1'b1;
    while (nv < 3 && t < 4000) begin
      @(negedge clk);
      t++;
      if (vld_a === 1'b1) nv++;
    end
    ena_a = 1'b0;
    while (nb_a !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (t >= 4000) chk("t2_timeout", 32'd0, 32'd1);
    chk("t2_busy", 32'(busy_a - b0), 32'd1005);
    chk("t2_rises", 32'(rise_a - r0), 32'd96);
    score_a("t2_w0");
    score_a("t2_w1");
    score_a("t2_w2");
    if (gaps.size() >= g0 + 3) begin
      chk("t2_gap1", 32'(gaps[g0+1]), 32'd6);
      chk("t2_gap2", 32'(gaps[g0+2]), 32'd6);
    end else begin
      chk("t2_gapcnt", 32'(gaps.size() - g0), 32'd3);
    end
    last_a = 32'hFFFF_FFFF;

    // CLK_DIV=1 instance
    b0 = busy_b; r0 = rise_b; v0 = valid_b; t = 0;
    sens_q_b.push_back(32'h3C5A_96E1);
    exp_q_b.push_back(32'h3C5A_96E1);
    ena_b = 1'b1;
    @(negedge clk);
    ena_b = 1'b0;
    while (nb_b !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (t >= 500) chk("t3_timeout", 32'd0, 32'd1);
    chk("t3_busy", 32'(busy_b - b0), 32'd67);
    chk("t3_rises", 32'(rise_b - r0), 32'd32);
    chk("t3_vcnt", 32'(valid_b - v0), 32'd1);
    if (rx_q_b.size() > 0 && exp_q_b.size() > 0)
      chk("t3_data", rx_q_b.pop_front(), exp_q_b.pop_front());
    else
      chk("t3_present", 32'(rx_q_b.size()), 32'd1);

    // Reset mid-SHIFT
    r0 = rise_a; v0 = valid_a; t = 0;
    sens_q_a.push_back(32'h1234_5678);
    ena_a = 1'b1;
    @(negedge clk);
    ena_a = 1'b0;
    while (rise_a - r0 < 12 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("t4_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_cs_n", 32'(cs_a), 32'd1);
    chk("t4_sclk", 32'(sclk_a), 32'd0);
    chk("t4_nb", 32'(nb_a), 32'd1);
    chk("t4_data", data_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_novld", 32'(valid_a - v0), 32'd0);
    last_a = 32'h0;
    run_a("t4_after", 32'hDEAD_BEEF, 0);

    // Random ena activity during a transfer
    run_a("t5", 32'h5A5A_C3C3, 1);

    // Thermocouple word field extraction
    run_a("t6", 32'h0640_1900, 0);
    chk("t6_tc", 32'(data_a[31:18]), 32'h0190);
    chk("t6_junc", 32'(data_a[15:4]), 32'h190);

    chk("leftover_obs", 32'(rx_q_a.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_master_rx.md
Name: spi_master_rx

Overview:
Receive-only SPI master that feeds the thermocouple controller. It reads one DATA_W-bit frame (MAX31855-style: mode 0, MSB first) from the sensor when the controller requests it. It then presents the word on spi_rx_data and reports idle through spi_not_busy. It is the stage directly upstream of the thermocouple controller and drives the sensor pins cs_n and sclk.

Parameters:
DATA_W, 32, bits per frame; also the width of spi_rx_data.
CLK_DIV, 5, clk cycles per sclk half-period; must be at least 1. sclk frequency = f_clk/(2*CLK_DIV).
CBITS, $clog2(2*DATA_W+1), width of the edge counter.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  reset, asynchronous, active-high.
spi_ena  input  1  transfer request; sampled only in IDLE.
miso  input  1  serial data from the sensor.
spi_not_busy  output  1  1 only in IDLE.
spi_rx_data  output  DATA_W  last completed frame; MSB is the first bit received.
spi_rx_valid  output  1  one-cycle pulse when spi_rx_data is updated.
cs_n  output  1  sensor chip select, active low.
sclk  output  1  serial clock; idles low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, cs_n=1, sclk=0, spi_not_busy=1, spi_rx_data=0, spi_rx_valid=0.
  - Shift register, divider counter and edge counter are cleared.
- Divider: a counter runs 0..CLK_DIV-1 in every non-IDLE state and wraps. A "tick" is the cycle where the counter equals CLK_DIV-1.
- IDLE:
  - cs_n=1, sclk=0, spi_not_busy=1.
  - If spi_ena=1 at a clk edge, the next cycle enters SETUP with cs_n=0 and spi_not_busy=0.
- SETUP:
  - cs_n=0, sclk=0, lasts CLK_DIV cycles (provides t_CSS).
  - On tick, go to SHIFT with the edge counter at 0.
- SHIFT:
  - On each tick, sclk toggles and the edge counter increments.
  - On a 0->1 toggle, miso as sampled at that clk edge is shifted into the LSB; the register shifts left.
  - After 2*DATA_W toggles (sclk back at 0), go to HOLD.
  - Exactly DATA_W rising sclk edges occur per frame.
- HOLD: cs_n=0, sclk=0, lasts CLK_DIV cycles; then go to DONE.
- DONE:
  - On entry, spi_rx_data <= shift register and spi_rx_valid=1 for that single cycle.
  - cs_n=1, sclk=0, lasts CLK_DIV cycles (provides minimum CS-high time); then go to IDLE.
- Busy duration: spi_not_busy=0 for exactly (2*DATA_W+3)*CLK_DIV cycles per transfer (335 at the defaults).
- spi_rx_data is stable except on the DONE entry cycle. It holds the previous frame throughout a transfer.
- spi_ena changes while not in IDLE are ignored. A transfer is never aborted except by rst.
- If spi_ena is held high, transfers run back-to-back: IDLE lasts exactly 1 cycle between frames.
- spi_ena dropping in the same cycle that IDLE is entered: that cycle's sampled value decides whether a new transfer starts.
- sclk and cs_n are registered outputs with no combinational path from inputs.
- The state encoding has 5 states. Any unreachable encoding goes to IDLE with cs_n=1 on the next clk.

Test Plan:
1. Reset, then a single 1-cycle spi_ena pulse with the sensor model driving 32'hA5C3_0F81 MSB-first, changing on sclk falling edges -> exactly 32 sclk rising edges; spi_rx_data=32'hA5C3_0F81 with a 1-cycle spi_rx_valid; spi_not_busy low for 335 cycles.
2. spi_ena held high for three frames (32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF) -> three consecutive valid words in order; cs_n high for exactly 6 cycles between frames (5 DONE + 1 IDLE).
3. With CLK_DIV=1 -> sclk period of 2 clk cycles; frame received correctly; busy for 67 cycles.
4. rst asserted mid-SHIFT (after bit 12) -> cs_n=1, sclk=0, spi_not_busy=1 immediately; spi_rx_data=0; no valid pulse; the next request yields a correct full frame.
5. spi_ena toggled randomly during a transfer -> no effect on timing or data; spi_rx_data keeps the prior frame until DONE.
6. Thermocouple controller connected downstream, sensor returning 32'h0640_1900 -> controller reads tc_temp_data=14'h0190 and junction_temp_data=12'h190.
